hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage ARM core. It drives the enable/clear inputs of the F/D/E/M/W pipeline registers and produces the E-stage forwarding selects. It detects load-use hazards, taken branches, in-flight PC writes and multi-cycle data-memory accesses. It also keeps a saturating count of fetch-stall cycles for performance monitoring.

Parameters:
MEM_LAT, 2, data-memory access latency in cycles (>=1); an access holds M for exactly MEM_LAT cycles
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ra1_d  in  4  D-stage source register 1
ra2_d  in  4  D-stage source register 2
ra1_e  in  4  E-stage source register 1
ra2_e  in  4  E-stage source register 2
wa_e  in  4  E-stage destination
wa_m  in  4  M-stage destination
wa_w  in  4  W-stage destination
regwrite_e  in  1  E writes register file
regwrite_m  in  1  M writes register file
regwrite_w  in  1  W writes register file
memtoreg_e  in  1  E instruction is a load
memaccess_m  in  1  M instruction is a load/store
pcs_d  in  1  D instruction writes PC
pcs_e  in  1  E instruction writes PC
pcs_m  in  1  M instruction writes PC
pcsrc_w  in  1  W writes PC this cycle
branch_e  in  1  branch taken in E
fwd_a_e  out  2  SrcA select: 00 regfile, 01 W result, 10 M ALU result
fwd_b_e  out  2  SrcB select, same encoding
en_f  out  1  PC register enable
en_d  out  1  F/D register enable
en_e  out  1  D/E register enable
en_m  out  1  E/M register enable
en_w  out  1  M/W register enable (constant 1)
clr_d  out  1  F/D flush
clr_e  out  1  D/E flush
clr_w  out  1  M/W flush (bubble)
stall_cycles  out  CNT_W  saturating count of cycles with en_f=0

Behaviour:
- Pipeline registers clear only when their enable is high. Invariant: clr_x=1 implies en_x=1 in every cycle.
- Forwarding (combinational, per operand): select 10 if regwrite_m and ra_e==wa_m; else 01 if regwrite_w and ra_e==wa_w; else 00. The M match wins when M and W both match.
- ldr_stall = memtoreg_e & regwrite_e & (ra1_d==wa_e | ra2_d==wa_e).
- pc_pend = pcs_d | pcs_e | pcs_m.
- Memory FSM, states IDLE and WAIT, with a down-counter cnt of width clog2(MEM_LAT):
  - IDLE: if memaccess_m and MEM_LAT>1, then mem_stall=1; go to WAIT with cnt=MEM_LAT-2. Otherwise mem_stall=0.
  - WAIT: if cnt!=0, mem_stall=1 and cnt decrements. If cnt==0, mem_stall=0 and the FSM returns to IDLE, ignoring memaccess_m in that cycle.
  - MEM_LAT=1: the FSM never leaves IDLE.
- mem_stall is Mealy, asserted in the same cycle memaccess_m is first seen.
- Output priority:
  1. mem_stall=1: en_f=en_d=en_e=en_m=0; clr_d=clr_e=0; clr_w=1.
  2. Otherwise:
     - en_f = ~(ldr_stall|pc_pend)
     - en_d = ~ldr_stall | clr_d
     - clr_d = pc_pend | pcsrc_w | branch_e
     - clr_e = ldr_stall | branch_e
     - en_e = en_m = 1
     - clr_w = 0
- Simultaneous ldr_stall and branch_e: the branch wins, so D is flushed (clr_d=1, en_d=1) and E is flushed.
- stall_cycles: increments on every rising clk where en_f==0. It saturates at all-ones with no wrap.
- Reset (async, any time including mid-WAIT): state=IDLE, cnt=0, stall_cycles=0 immediately. Other outputs then follow the IDLE equations from the current inputs.

Test Plan:
- LDR r2 in E (memtoreg_e=1, regwrite_e=1, wa_e=2) and ra1_d=2 -> en_f=0, en_d=0, clr_e=1 for 1 cycle; stall_cycles=1 afterwards.
- regwrite_m=1, wa_m=3, regwrite_w=1, wa_w=3, ra1_e=3, ra2_e=3 -> fwd_a_e=10, fwd_b_e=10. With regwrite_m=0 -> both 01. With ra_e=4 -> both 00.
- MEM_LAT=4, memaccess_m pulses with an instruction held -> mem_stall for 3 cycles (en_f..en_m=0, clr_w=1), released on the 4th. Back-to-back access next cycle -> another 3 stall cycles.
- branch_e=1 together with ldr_stall=1 -> clr_d=1, en_d=1, clr_e=1, en_f=0.
- pcs_d=1, then pcs_e, then pcs_m, then pcsrc_w across 4 cycles -> en_f=0 for 3 cycles and clr_d=1 for all 4.
- Reset asserted mid-WAIT (MEM_LAT=4, cycle 2) -> en_* back to 1 combinationally and stall_cycles=0. CNT_W=2 with 5 stall cycles -> stall_cycles holds at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush enables for F/D/E/M/W, E-stage
// forwarding selects, multi-cycle data-memory hold and a fetch-stall counter.
module hazard_ctrl #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ra1_d,
    input  logic [3:0]       ra2_d,
    input  logic [3:0]       ra1_e,
    input  logic [3:0]       ra2_e,
    input  logic [3:0]       wa_e,
    input  logic [3:0]       wa_m,
    input  logic [3:0]       wa_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             memaccess_m,
    input  logic             pcs_d,
    input  logic             pcs_e,
    input  logic             pcs_m,
    input  logic             pcsrc_w,
    input  logic             branch_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic             clr_d,
    output logic             clr_e,
    output logic             clr_w,
    output logic [CNT_W-1:0] stall_cycles
);

    // Counter needs at least one bit even when MEM_LAT is 1 or 2.
    localparam int unsigned CNT_BITS = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned CNT_LOAD = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(CNT_LOAD);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic               mem_stall;
    logic               ldr_stall;
    logic               pc_pend;

    // State, memory countdown and stall counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Memory-access FSM: holds M for MEM_LAT cycles; mem_stall is Mealy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memaccess_m && (MEM_LAT > 1)) begin
                    mem_stall = 1'b1;
                    state_d   = S_WAIT;
                    cnt_d     = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_BITS'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Forwarding selects: M result takes precedence over W result.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (regwrite_m && (ra1_e == wa_m))      fwd_a_e = 2'b10;
        else if (regwrite_w && (ra1_e == wa_w)) fwd_a_e = 2'b01;
        if (regwrite_m && (ra2_e == wa_m))      fwd_b_e = 2'b10;
        else if (regwrite_w && (ra2_e == wa_w)) fwd_b_e = 2'b01;
    end

    // Pipeline enables and flushes; a memory hold freezes everything upstream of W.
    always_comb begin
        ldr_stall = memtoreg_e && regwrite_e && ((ra1_d == wa_e) || (ra2_d == wa_e));
        pc_pend   = pcs_d || pcs_e || pcs_m;
        en_f      = 1'b1;
        en_d      = 1'b1;
        en_e      = 1'b1;
        en_m      = 1'b1;
        en_w      = 1'b1;
        clr_d     = 1'b0;
        clr_e     = 1'b0;
        clr_w     = 1'b0;
        if (mem_stall) begin
            en_f  = 1'b0;
            en_d  = 1'b0;
            en_e  = 1'b0;
            en_m  = 1'b0;
            clr_w = 1'b1;
        end else begin
            clr_d = pc_pend || pcsrc_w || branch_e;
            clr_e = ldr_stall || branch_e;
            en_f  = !(ldr_stall || pc_pend);
            en_d  = !ldr_stall || clr_d;
        end
    end

    // Saturating count of cycles with fetch stalled.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!en_f && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
